// File: rtl/nibble_assembler.sv
// nibble_assembler: packs a stream of 4-bit nibbles into a word under a rotating one-hot slot pointer
// Ports: clk, rst_n (sync, active low); in_nib/in_valid/in_ready nibble input;
// flush emits the partial word; wr_sel is the one-hot slot for the next nibble;
// out_word/out_valid/out_ready is the one-word output buffer.
// Optional macro NIBASM_LEN_EN adds out_len, the nibble count of out_word.
module nibble_assembler #(
  parameter int NIBBLES = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             in_nib,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [NIBBLES-1:0]     wr_sel,
  output logic [4*NIBBLES-1:0]   out_word,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef NIBASM_LEN_EN
  , output logic [$clog2(NIBBLES+1)-1:0] out_len
`endif
);
  localparam int W = 4*NIBBLES;
  localparam int CW = $clog2(NIBBLES+1);
  localparam logic [NIBBLES-1:0] SLOT0 = MSB_FIRST ? {1'b1, {(NIBBLES-1){1'b0}}} : {{(NIBBLES-1){1'b0}}, 1'b1};
  logic [W-1:0] acc, merged;
  logic [CW-1:0] count;
  logic [NIBBLES-1:0] next_sel;
  logic pend, last, free, take, fl, emit;
  always_comb begin
    merged = acc;
    for (int i = 0; i < NIBBLES; i++) if (wr_sel[i]) merged[4*i +: 4] = in_nib;
  end
  assign last = count == CW'(NIBBLES-1);
  assign free = !out_valid || out_ready;
  assign in_ready = !last || free;
  assign take = in_valid && in_ready;
  assign fl = flush || pend;
  // a flush only emits when something is in the word (held or arriving now)
  assign emit = free && ((take && last) || (fl && (count != '0 || take)));
  assign next_sel = MSB_FIRST ? {wr_sel[0], wr_sel[NIBBLES-1:1]} : {wr_sel[NIBBLES-2:0], wr_sel[NIBBLES-1]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      count <= '0;
      wr_sel <= SLOT0;
      out_word <= '0;
      out_valid <= 1'b0;
      pend <= 1'b0;
`ifdef NIBASM_LEN_EN
      out_len <= '0;
`endif
    end else if (emit) begin
      out_word <= take ? merged : acc;
      out_valid <= 1'b1;
      acc <= '0;
      count <= '0;
      wr_sel <= SLOT0;
      pend <= 1'b0;
`ifdef NIBASM_LEN_EN
      out_len <= count + CW'(take);
`endif
    end else begin
      if (take) begin
        acc <= merged;
        count <= count + CW'(1);
        wr_sel <= next_sel;
      end
      out_valid <= out_valid && !out_ready;
      // a flush that cannot emit yet waits for the buffer to free
      pend <= fl && (count != '0 || take);
    end
  end
endmodule

// File: tb/tb_nibble_assembler.sv
// tb_nibble_assembler: directed and randomized checks of nibble_assembler against a queue-based model
module tb_nibble_assembler;
  localparam int N = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n = 0, in_valid = 0, flush = 0, out_ready = 0, in_ready, out_valid;
  logic [3:0] in_nib = 0, wr_sel;
  logic [15:0] out_word;
  logic b_rst_n = 0, b_in_valid = 0, b_flush = 0, b_out_ready = 0, b_in_ready, b_out_valid;
  logic [3:0] b_in_nib = 0, b_wr_sel;
  logic [15:0] b_out_word;
`ifdef NIBASM_LEN_EN
  logic [2:0] out_len, b_out_len;
`endif
  int checks = 0, failures = 0;

  nibble_assembler #(.NIBBLES(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_nib(in_nib), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .wr_sel(wr_sel), .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready)
`ifdef NIBASM_LEN_EN
    , .out_len(out_len)
`endif
  );

  nibble_assembler #(.NIBBLES(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(b_rst_n), .in_nib(b_in_nib), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flush(b_flush), .wr_sel(b_wr_sel), .out_word(b_out_word), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef NIBASM_LEN_EN
    , .out_len(b_out_len)
`endif
  );

  // reference model: the current word is a list of accepted nibbles, the buffer a single slot
  logic [3:0] mq[$];
  logic mv = 0, mp = 0, m_free, m_take, m_f;
  logic [15:0] mw = 0;
  logic [2:0] ml = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mv = 0; mw = 0; ml = 0; mp = 0;
    end else begin
      m_free = !mv || out_ready;
      m_take = in_valid && (mq.size() != N-1 || m_free);
      if (mv && out_ready) mv = 0;
      if (m_take) mq.push_back(in_nib);
      m_f = flush || mp;
      if (mq.size() == N || (m_f && m_free && mq.size() != 0)) begin
        mw = 0;
        foreach (mq[k]) mw = mw | (16'(mq[k]) << (4*(N-1-k)));
        ml = 3'(mq.size());
        mv = 1;
        mp = 0;
        mq.delete();
      end else mp = m_f && mq.size() != 0;
    end
  end

  task automatic drive(input logic v, input logic [3:0] n, input logic f, input logic r);
    @(negedge clk);
    in_valid = v; in_nib = n; flush = f; out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_word !== 16'h0) begin failures++; $display("FAIL reset_out_word got=%h exp=0000", out_word); end
    checks++; if (wr_sel !== 4'b1000) begin failures++; $display("FAIL reset_wr_sel got=%b exp=1000", wr_sel); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (b_wr_sel !== 4'b0001) begin failures++; $display("FAIL reset_lsb_wr_sel got=%b exp=0001", b_wr_sel); end
`ifdef NIBASM_LEN_EN
    checks++; if (out_len !== 3'd0) begin failures++; $display("FAIL reset_out_len got=%0d exp=0", out_len); end
`endif
    rst_n = 1; b_rst_n = 1;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(i+1), 0, 1);
      checks++; if (wr_sel !== (4'b1000 >> i)) begin failures++; $display("FAIL basic_wr_sel[%0d] got=%b exp=%b", i, wr_sel, 4'b1000 >> i); end
    end
    drive(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_word !== 16'h1234) begin failures++; $display("FAIL basic_out_word got=%h exp=1234", out_word); end
    checks++; if (wr_sel !== 4'b1000) begin failures++; $display("FAIL basic_wr_sel_wrap got=%b exp=1000", wr_sel); end
  endtask

  task automatic test_backpressure;
    logic [3:0] nibs[16] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    logic [15:0] exp_words[4] = '{16'hABCD, 16'hEF01, 16'h2345, 16'h6789};
    logic [15:0] got[$];
    int idx = 0, stalls = 0, bad_stall = 0, tries = 0;
    logic r = 0;
    while (idx < 16 && tries < 100) begin
      tries++;
      drive(1, nibs[idx], 0, r);
      if (out_valid && r) got.push_back(out_word);
      if (in_ready) idx++;
      else begin
        stalls++;
        if (idx != 7) bad_stall++;
        if (stalls == 1) begin
          checks++; if (out_valid !== 1'b1 || out_word !== 16'hABCD) begin failures++; $display("FAIL bp_held_word got=%b/%h exp=1/abcd", out_valid, out_word); end
        end
        if (stalls == 3) r = 1;
      end
    end
    repeat (4) begin
      drive(0, 0, 0, 1);
      if (out_valid) got.push_back(out_word);
    end
    checks++; if (idx != 16) begin failures++; $display("FAIL bp_all_accepted got=%0d exp=16", idx); end
    checks++; if (stalls != 3) begin failures++; $display("FAIL bp_stall_count got=%0d exp=3", stalls); end
    checks++; if (bad_stall != 0) begin failures++; $display("FAIL bp_stall_position got=%0d exp=0", bad_stall); end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_word_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_words[i]) begin failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got[i], exp_words[i]); end
    end
  endtask

  task automatic test_flush;
    drive(1, 7, 0, 1);
    drive(1, 8, 0, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_word !== 16'h7800) begin failures++; $display("FAIL flush_out_word got=%h exp=7800", out_word); end
    checks++; if (wr_sel !== 4'b1000) begin failures++; $display("FAIL flush_wr_sel got=%b exp=1000", wr_sel); end
`ifdef NIBASM_LEN_EN
    checks++; if (out_len !== 3'd2) begin failures++; $display("FAIL flush_out_len got=%0d exp=2", out_len); end
`endif
  endtask

  task automatic test_simul_flush;
    drive(1, 5, 0, 1);
    drive(1, 6, 0, 1);
    drive(1, 7, 0, 1);
    drive(1, 8, 1, 1);
    drive(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_word !== 16'h5678) begin failures++; $display("FAIL simul_word got=%b/%h exp=1/5678", out_valid, out_word); end
`ifdef NIBASM_LEN_EN
    checks++; if (out_len !== 3'd4) begin failures++; $display("FAIL simul_out_len got=%0d exp=4", out_len); end
`endif
    drive(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL simul_single_word got=%b exp=0", out_valid); end
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_flush got=%b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset;
    drive(1, 9, 0, 1);
    drive(1, 9, 0, 1);
    drive(0, 0, 0, 1);
    checks++; if (wr_sel !== 4'b0010) begin failures++; $display("FAIL mid_wr_sel_before got=%b exp=0010", wr_sel); end
    rst_n = 0;
    drive(0, 0, 0, 1);
    rst_n = 1;
    checks++; if (out_valid !== 1'b0 || out_word !== 16'h0) begin failures++; $display("FAIL mid_reset_out got=%b/%h exp=0/0000", out_valid, out_word); end
    checks++; if (wr_sel !== 4'b1000) begin failures++; $display("FAIL mid_reset_wr_sel got=%b exp=1000", wr_sel); end
    drive(1, 1, 0, 1);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);
    drive(1, 1, 0, 1);
    drive(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_word !== 16'h1001) begin failures++; $display("FAIL mid_reset_word got=%b/%h exp=1/1001", out_valid, out_word); end
  endtask

  task automatic test_lsb_first;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = 1; b_in_nib = 4'(i+1); b_out_ready = 1;
      #1;
      checks++; if (b_wr_sel !== (4'b0001 << i)) begin failures++; $display("FAIL lsb_wr_sel[%0d] got=%b exp=%b", i, b_wr_sel, 4'b0001 << i); end
    end
    @(negedge clk);
    b_in_valid = 0;
    #1;
    checks++; if (b_out_valid !== 1'b1 || b_out_word !== 16'h4321) begin failures++; $display("FAIL lsb_word got=%b/%h exp=1/4321", b_out_valid, b_out_word); end
    checks++; if (b_wr_sel !== 4'b0001) begin failures++; $display("FAIL lsb_wr_sel_wrap got=%b exp=0001", b_wr_sel); end
  endtask

  task automatic test_random;
    logic [3:0] exp_sel;
    logic exp_rdy;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      exp_sel = 4'b1000 >> mq.size();
      exp_rdy = mq.size() != N-1 || !mv || out_ready;
      checks++; if (out_valid !== mv) begin failures++; $display("FAIL rand_out_valid c=%0d got=%b exp=%b", c, out_valid, mv); end
      checks++; if (out_word !== mw) begin failures++; $display("FAIL rand_out_word c=%0d got=%h exp=%h", c, out_word, mw); end
      checks++; if (wr_sel !== exp_sel) begin failures++; $display("FAIL rand_wr_sel c=%0d got=%b exp=%b", c, wr_sel, exp_sel); end
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
`ifdef NIBASM_LEN_EN
      checks++; if (out_len !== ml) begin failures++; $display("FAIL rand_out_len c=%0d got=%0d exp=%0d", c, out_len, ml); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_simul_flush();
    test_mid_reset();
    test_lsb_first();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_assembler.md
Name: nibble_assembler

Overview:
- Write-side counterpart of the one-hot nibble selector: accepts a stream of 4-bit nibbles and packs them into a 16-bit word, one slot per nibble, under a rotating one-hot slot pointer.
- Used to build display and entry words (e.g. keypad digits into the 4-digit hex display word).
- Valid/ready handshake on both sides; a one-word output buffer lets the next word fill while the previous word waits.

Parameters:
- NIBBLES, 4, number of nibble slots per word; word width = 4*NIBBLES.
- MSB_FIRST, 1, 1: first nibble lands in the top slot [15:12]; 0: first nibble lands in [3:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_nib  input  4  nibble data
- in_valid  input  1  in_nib is valid this cycle
- in_ready  output  1  assembler accepts in_nib this cycle
- flush  input  1  single-cycle pulse; emit the partial word, unfilled slots zero
- wr_sel  output  NIBBLES  one-hot slot the next accepted nibble is written to
- out_word  output  4*NIBBLES  assembled word
- out_valid  output  1  out_word holds a complete or flushed word
- out_ready  input  1  consumer takes out_word this cycle

Behaviour:
- All state updates on the rising clk edge. Reset is synchronous: the rst_n low at an edge overrides every other input.
- Reset values:
  - acc = 0, out_word = 0, out_valid = 0, fill count = 0.
  - wr_sel = slot 0 (MSB_FIRST=1: 4'b1000; MSB_FIRST=0: 4'b0001).
  - in_ready is 1 after reset.
- Input transfer occurs when in_valid && in_ready. The nibble is written into acc at the wr_sel slot. wr_sel then rotates one position (MSB_FIRST=1: shift right) and the count increments.
- States:
  - FILL (count < NIBBLES-1): in_ready = 1.
  - LAST (count == NIBBLES-1): in_ready = !out_valid || out_ready.
  - The accepting nibble in LAST completes the word:
    - out_word <= acc with the new nibble merged; out_valid <= 1.
    - acc <= 0, count <= 0, wr_sel <= slot 0.
  - Return to FILL.
- Output transfer occurs when out_valid && out_ready. It clears out_valid unless a new word is loaded in the same cycle; in that case out_valid stays 1 with the new word.
- Latency: out_valid asserts the cycle after the final nibble is accepted. Full throughput is one nibble per cycle when out_ready is held high.
- Backpressure: only the last nibble of a word can stall. Earlier nibbles always go into acc.
- Flush:
  - A flush with count > 0 behaves like completing the word: the current acc (unfilled slots 0) is loaded to out_word, then acc, count and wr_sel are reset.
  - It is honoured only when !out_valid || out_ready. Otherwise it is held pending internally until the buffer frees.
  - A flush with count == 0 and no nibble arriving is ignored (no empty word is emitted).
- Flush in the same cycle as an accepted nibble:
  - The nibble is included first, then the word is emitted.
  - If that nibble was the last one, the result is one word, not two.
- Invariant: wr_sel is always one-hot, never zero and never multi-hot.

Optional Feature:
- Macro NIBASM_LEN_EN.
- Defined:
  - Adds output port out_len, width $clog2(NIBBLES+1).
  - out_len gives the number of valid nibbles in out_word: NIBBLES for a full word, 1..NIBBLES-1 for a flushed word.
  - Reset value 0; it updates together with out_word.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, MSB_FIRST=1: feed 1,2,3,4 with out_ready=1 -> out_word=16'h1234 and out_valid=1 one cycle after the 4th nibble. wr_sel sequence is 1000, 0100, 0010, 0001, 1000.
- Backpressure: hold out_ready=0, send 16 nibbles A..F,0..9 -> first word 16'hABCD held. in_ready drops on the 8th nibble (value 1) only. Raise out_ready -> words 16'hEF01 then 16'h2345 in order, no loss.
- Flush: feed 7,8 then pulse flush -> out_word=16'h7800, out_len=2 (with NIBASM_LEN_EN). wr_sel returns to 1000.
- Simultaneous flush with the 4th nibble: 5,6,7 then 8+flush -> exactly one word 16'h5678. Flush with empty acc -> no out_valid.
- Mid-operation reset: accept 9,9 then rst_n=0 one cycle -> out_valid=0, out_word=0, wr_sel=1000. Next 4 nibbles 1,0,0,1 -> 16'h1001.
- MSB_FIRST=0: feed 1,2,3,4 -> out_word=16'h4321. wr_sel sequence is 0001, 0010, 0100, 1000.
